deck_shuffler: RTL and testbench
================================

DECK_SHUFFLER -- requirements
Module: deck_shuffler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 32, deck RAM word width.
- ADDRESS_WIDTH, 12, deck RAM address width.
- BASE_ADDR, 0, RAM address of card slot 0.
- DECK_SIZE, 52, number of cards; legal range 2..64.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a fresh deck plus shuffle.
- seed_load  in  1  load seed into the LFSR.
- seed  in  16  LFSR seed.
- busy  out  1  high while initialising or shuffling.
- done  out  1  one-cycle completion pulse.
- ram_wEn  out  1  deck RAM write enable.
- ram_addr  out  ADDRESS_WIDTH  RAM port-1 address (write and read).
- ram_addr2  out  ADDRESS_WIDTH  RAM port-2 read address.
- ram_dataIn  out  DATA_WIDTH  RAM write data.
- ram_dataOut  in  DATA_WIDTH  RAM port-1 read data.
- ram_dataOut2  in  DATA_WIDTH  RAM port-2 read data.
REQ-003 The attached RAM SHALL be treated as follows:
- It registers both read ports on the clk edge when ram_wEn=0; data is valid the following cycle.
- Its read outputs hold their value while ram_wEn=1.
- Writes go to ram_addr.

Function
REQ-004 States SHALL be IDLE, INIT, READ, WR1, WR2, DONE.
REQ-005 IDLE SHALL behave as follows:
- busy=0, ram_wEn=0.
- start=1 at a clk edge moves to INIT with card counter k=0.
- seed_load=1 loads seed into the LFSR; a zero seed loads 16'hACE1.
- If start and seed_load are both high, the seed loads on that edge and the shuffle uses it.
REQ-006 INIT SHALL behave as follows:
- Each cycle: ram_wEn=1, ram_addr=BASE_ADDR+k, ram_dataIn=k zero-extended.
- After k=DECK_SIZE-1 is written, go to READ with i=DECK_SIZE-1.
REQ-007 LFSR: 16-bit Galois, taps 16'hB400, shift right; advances every clk edge outside reset, including in IDLE.
REQ-008 READ SHALL behave as follows (Fisher-Yates step):
- j = (lfsr[7:0] * (i+1)) >> 8, computed at full width, giving 0 <= j <= i; j is latched.
- Outputs: ram_wEn=0, ram_addr=BASE_ADDR+i, ram_addr2=BASE_ADDR+j.
- Next state: WR1.
REQ-009 WR1 SHALL drive ram_wEn=1, ram_addr=BASE_ADDR+i, ram_dataIn=ram_dataOut2, then go to WR2.
REQ-010 WR2 SHALL behave as follows:
- Outputs: ram_wEn=1, ram_addr=BASE_ADDR+j, ram_dataIn=ram_dataOut (port-1 value held from READ).
- If i==1, go to DONE; else decrement i and go to READ.
REQ-011 When i==j, both writes SHALL target the same slot with the unchanged value; no special case.
REQ-012 DONE SHALL assert done=1 for exactly one cycle with ram_wEn=0, then return to IDLE.
REQ-013 busy SHALL be 1 in INIT, READ, WR1 and WR2, and 0 in IDLE and DONE.
REQ-014 Timing: busy SHALL be high for exactly DECK_SIZE + 3*(DECK_SIZE-1) cycles (205 at default), then done follows immediately.
REQ-015 start and seed_load SHALL be ignored while busy=1 or in DONE.
REQ-016 ram_addr2 SHALL equal ram_addr whenever not in READ.
REQ-017 ram_dataIn SHALL be 0 when ram_wEn=0.

Reset
REQ-018 reset_n=0 SHALL act asynchronously and set:
- state=IDLE, busy=0, done=0, ram_wEn=0.
- ram_addr=ram_addr2=BASE_ADDR, ram_dataIn=0.
- LFSR=16'hACE1, k=i=j=0.
REQ-019 Reset asserted mid-INIT or mid-shuffle SHALL abort with no further RAM writes; RAM contents are then undefined until the next completed run.
REQ-020 After reset release the block SHALL remain in IDLE until start.

Verification
REQ-021 Reset then start without seed_load -> busy high exactly 205 cycles, one-cycle done; RAM[0..51] is a permutation of 0..51 matching a golden model seeded with 16'hACE1.
REQ-022 seed_load with seed=16'h1234, then start -> RAM order matches the golden model for seed 1234; a repeat run from the same seed gives an identical order.
REQ-023 seed_load with seed=0 -> result identical to a run seeded with 16'hACE1.
REQ-024 Pulse start and seed_load during busy -> no effect: cycle count, RAM result and LFSR sequence unchanged.
REQ-025 Assert reset_n=0 at shuffle cycle 100 -> ram_wEn drops in the same cycle; busy=0 and state IDLE. A new start then completes with a valid permutation.
REQ-026 DECK_SIZE=2, BASE_ADDR=12'h100 -> INIT writes 0 and 1 at 12'h100 and 12'h101; busy lasts 5 cycles; the final contents are {0,1} or {1,0} per the golden model.

Source files
------------

// File: rtl/deck_shuffler.sv
// Deck shuffler: fills an external dual-read RAM with cards 0..DECK_SIZE-1 and
// then permutes them in place with a Fisher-Yates walk driven by a 16-bit
// Galois LFSR. The RAM registers its reads, so every swap costs three cycles:
// one to read both slots and two to write them back crossed over.
module deck_shuffler #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int BASE_ADDR     = 0,
    parameter int DECK_SIZE     = 52
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     seed_load,
    input  logic [15:0]              seed,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_addr2,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut2
);

    // Seven bits hold any card index up to 63 and also i+1 up to 64.
    localparam int CW = 7;

    localparam logic [15:0]              LFSR_RESET = 16'hACE1;
    localparam logic [15:0]              LFSR_TAPS  = 16'hB400;
    localparam logic [ADDRESS_WIDTH-1:0] BASE       = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]            LAST_CARD  = CW'(DECK_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ,
        WR1,
        WR2,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [15:0]              lfsrNext;
    logic [CW-1:0]            k_q, k_d;
    logic [CW-1:0]            i_q, i_d;
    logic [CW-1:0]            j_q, j_d;
    logic [15:0]              jProduct;
    logic [CW-1:0]            jCalc;
    logic [ADDRESS_WIDTH-1:0] jAddr;

    // One Galois step: shift right and fold the taps back in when bit 0 falls out.
    assign lfsrNext = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // Scaling an 8-bit random value by (i+1) and keeping the top bits yields j in 0..i
    // without a divider; the product never exceeds 255*64, so 16 bits suffice.
    assign jProduct = {8'h00, lfsr_q[7:0]} * {9'h000, i_q + 7'd1};
    assign jCalc    = CW'(jProduct >> 8);
    assign jAddr    = BASE + ADDRESS_WIDTH'(jCalc);

    // The second read port only matters while both swap partners are fetched.
    assign ram_addr2 = (state_q == READ) ? jAddr : ram_addr;

    // State, LFSR and card indices; reset returns to a quiet IDLE with the default seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_RESET;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next-state and RAM-port decode; the LFSR free-runs unless a seed is taken in IDLE.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsrNext;
        k_d        = k_q;
        i_d        = i_q;
        j_d        = j_q;
        busy       = 1'b0;
        done       = 1'b0;
        ram_wEn    = 1'b0;
        ram_addr   = BASE;
        ram_dataIn = '0;

        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 16'h0000) ? LFSR_RESET : seed;
                end
                if (start) begin
                    state_d = INIT;
                    k_d     = '0;
                end
            end

            INIT: begin
                busy       = 1'b1;
                ram_wEn    = 1'b1;
                ram_addr   = BASE + ADDRESS_WIDTH'(k_q);
                ram_dataIn = DATA_WIDTH'(k_q);
                if (k_q == LAST_CARD) begin
                    state_d = READ;
                    i_d     = LAST_CARD;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end

            READ: begin
                busy     = 1'b1;
                ram_addr = BASE + ADDRESS_WIDTH'(i_q);
                j_d      = jCalc;
                state_d  = WR1;
            end

            WR1: begin
                busy       = 1'b1;
                ram_wEn    = 1'b1;
                ram_addr   = BASE + ADDRESS_WIDTH'(i_q);
                ram_dataIn = ram_dataOut2;
                state_d    = WR2;
            end

            WR2: begin
                // Port-1 output still holds slot i from READ because the RAM froze its
                // read registers during the WR1 write.
                busy       = 1'b1;
                ram_wEn    = 1'b1;
                ram_addr   = BASE + ADDRESS_WIDTH'(j_q);
                ram_dataIn = ram_dataOut;
                if (i_q == 7'd1) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q - 7'd1;
                    state_d = READ;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: a full-size deck at address 0 and a two-card deck at
// 12'h100, each with its own behavioural RAM; final RAM contents are compared
// against a Fisher-Yates reference computed directly from the LFSR sequence.
module tb_deck_shuffler;

    localparam int          N          = 52;
    localparam int          SN         = 2;
    localparam logic [11:0] SBASE      = 12'h100;
    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    int nChecks = 0;
    int nFails  = 0;

    logic        clk;
    logic        reset_n;
    logic        start, seed_load;
    logic [15:0] seed;
    logic        busy, done, ram_wEn;
    logic [11:0] ram_addr, ram_addr2;
    logic [31:0] ram_dataIn, ram_dataOut, ram_dataOut2;

    logic        sStart, sSeedLoad;
    logic [15:0] sSeed;
    logic        sBusy, sDone, sWEn;
    logic [11:0] sAddr, sAddr2;
    logic [31:0] sDataIn, sDataOut, sDataOut2;

    logic [31:0] memA [0:4095];
    logic [31:0] memB [0:4095];
    int          writesA = 0;

    deck_shuffler #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(0), .DECK_SIZE(N)
    ) dutBig (
        .clk(clk), .reset_n(reset_n), .start(start), .seed_load(seed_load), .seed(seed),
        .busy(busy), .done(done), .ram_wEn(ram_wEn), .ram_addr(ram_addr),
        .ram_addr2(ram_addr2), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut), .ram_dataOut2(ram_dataOut2)
    );

    deck_shuffler #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR('h100), .DECK_SIZE(SN)
    ) dutSmall (
        .clk(clk), .reset_n(reset_n), .start(sStart), .seed_load(sSeedLoad), .seed(sSeed),
        .busy(sBusy), .done(sDone), .ram_wEn(sWEn), .ram_addr(sAddr),
        .ram_addr2(sAddr2), .ram_dataIn(sDataIn),
        .ram_dataOut(sDataOut), .ram_dataOut2(sDataOut2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deck RAM for the large instance: registered reads, outputs frozen during writes.
    always @(posedge clk) begin
        if (ram_wEn) begin
            memA[ram_addr] <= ram_dataIn;
            writesA        <= writesA + 1;
        end else begin
            ram_dataOut  <= memA[ram_addr];
            ram_dataOut2 <= memA[ram_addr2];
        end
    end

    // Deck RAM for the two-card instance.
    always @(posedge clk) begin
        if (sWEn) begin
            memB[sAddr] <= sDataIn;
        end else begin
            sDataOut  <= memB[sAddr];
            sDataOut2 <= memB[sAddr2];
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d failures so far", nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] stepN(input logic [15:0] x, input int n);
        logic [15:0] v;
        v = x;
        for (int t = 0; t < n; t++) v = lfsrStep(v);
        return v;
    endfunction

    // Reference shuffle: s is the LFSR value in the first INIT cycle. The first
    // swap reads the LFSR n cycles later and each swap takes three cycles.
    task automatic goldenDeck(input logic [15:0] s, input int n, output int deck [0:63]);
        logic [15:0] l;
        int          j, tmp;
        for (int k = 0; k < 64; k++) deck[k] = k;
        l = stepN(s, n);
        for (int i = n - 1; i >= 1; i--) begin
            j       = (int'(l[7:0]) * (i + 1)) >> 8;
            tmp     = deck[i];
            deck[i] = deck[j];
            deck[j] = tmp;
            l       = stepN(l, 3);
        end
    endtask

    // Drives one full-size run from the current negedge and checks timing, INIT writes,
    // port invariants, the done pulse and the final deck.
    task automatic runBig(input logic [15:0] seedV, input bit loadSeed, input logic [15:0] expS,
                          input bit pulse, input string tag);
        int deck [0:63];
        int cnt, bad, memBad;
        goldenDeck(expS, N, deck);
        start = 1'b1; seed_load = loadSeed; seed = seedV;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        cnt = 0; bad = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (cnt < N) begin
                if (ram_wEn !== 1'b1 || ram_addr !== 12'(cnt) || ram_dataIn !== 32'(cnt)) bad++;
            end
            if (ram_wEn === 1'b1 && ram_addr2 !== ram_addr) bad++;
            if (ram_wEn === 1'b0 && ram_dataIn !== 32'd0) bad++;
            if (done !== 1'b0) bad++;
            if (pulse && (cnt % 37 == 5)) begin
                start = 1'b1; seed_load = 1'b1; seed = 16'($urandom);
            end else begin
                start = 1'b0; seed_load = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        start = 1'b0; seed_load = 1'b0;
        nChecks++;
        if (cnt !== 4 * N - 3) begin
            nFails++;
            $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", tag, cnt, 4 * N - 3);
        end
        nChecks++;
        if (bad !== 0) begin
            nFails++;
            $display("[TB] FAIL %s port_invariants: got %0d violations expected 0", tag, bad);
        end
        nChecks++;
        if ({done, ram_wEn} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL %s done_pulse: got done=%b wEn=%b expected done=1 wEn=0", tag, done, ram_wEn);
        end
        if (pulse) begin
            start = 1'b1; seed_load = 1'b1; seed = 16'h5555;
        end
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        nChecks++;
        if ({busy, done} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL %s after_done: got busy=%b done=%b expected 0 0", tag, busy, done);
        end
        memBad = 0;
        for (int k = 0; k < N; k++) begin
            if (memA[k] !== 32'(deck[k])) memBad++;
        end
        nChecks++;
        if (memBad !== 0) begin
            nFails++;
            $display("[TB] FAIL %s deck_order: got %0d wrong slots (slot0=%0d) expected 0 (slot0=%0d)",
                     tag, memBad, memA[0], deck[0]);
        end
    endtask

    // Waits a random number of idle cycles after reset release, then starts without a seed.
    task automatic idleThenStart(input string tag);
        int d, idleBad;
        d = $urandom_range(0, 15);
        idleBad = 0;
        repeat (d) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || ram_wEn !== 1'b0) idleBad++;
        end
        nChecks++;
        if (idleBad !== 0) begin
            nFails++;
            $display("[TB] FAIL %s idle_hold: got %0d active cycles expected 0", tag, idleBad);
        end
        runBig(16'h0000, 1'b0, stepN(LFSR_RESET, d + 1), 1'b0, tag);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 16'h0000;
        sStart = 1'b0; sSeedLoad = 1'b0; sSeed = 16'h0000;
        #2;
        nChecks++;
        if ({busy, done, ram_wEn} !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, ram_wEn});
        end
        nChecks++;
        if (ram_addr !== 12'h000 || ram_addr2 !== 12'h000) begin
            nFails++;
            $display("[TB] FAIL reset_addr: got %h/%h expected 000/000", ram_addr, ram_addr2);
        end
        nChecks++;
        if (ram_dataIn !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL reset_dataIn: got %h expected 0", ram_dataIn);
        end
        nChecks++;
        if (sAddr !== SBASE || sAddr2 !== SBASE || sWEn !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_small_addr: got %h/%h wEn=%b expected %h/%h wEn=0",
                     sAddr, sAddr2, sWEn, SBASE, SBASE);
        end
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if ({busy, done, ram_wEn} !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL reset_held: got %b expected 000", {busy, done, ram_wEn});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_reset_then_start();
        idleThenStart("reset_start");
    endtask

    task automatic test_seed_1234();
        runBig(16'h1234, 1'b1, 16'h1234, 1'b0, "seed1234_a");
        runBig(16'h1234, 1'b1, 16'h1234, 1'b0, "seed1234_b");
    endtask

    task automatic test_seed_zero();
        runBig(16'h0000, 1'b1, LFSR_RESET, 1'b0, "seed_zero");
    endtask

    task automatic test_seed_then_wait();
        logic [15:0] sv;
        int          d;
        sv = 16'($urandom_range(1, 65535));
        seed_load = 1'b1; seed = sv;
        @(negedge clk);
        seed_load = 1'b0;
        d = $urandom_range(0, 20);
        repeat (d) @(negedge clk);
        runBig(16'hFFFF, 1'b0, stepN(sv, d + 1), 1'b0, "seed_wait");
    endtask

    task automatic test_ignore_during_busy();
        logic [15:0] sv;
        sv = 16'($urandom_range(1, 65535));
        runBig(sv, 1'b1, sv, 1'b1, "busy_pulses");
    endtask

    task automatic test_random_seeds();
        logic [15:0] sv;
        for (int r = 0; r < 3; r++) begin
            sv = 16'($urandom);
            runBig(sv, 1'b1, (sv == 16'h0000) ? LFSR_RESET : sv, 1'b0, "random_seed");
        end
    endtask

    task automatic test_reset_abort();
        int wr0;
        start = 1'b1; seed_load = 1'b1; seed = 16'($urandom_range(1, 65535));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        repeat (99) @(negedge clk);
        nChecks++;
        if ({busy, ram_wEn} !== 2'b11) begin
            nFails++;
            $display("[TB] FAIL abort_precondition: got busy=%b wEn=%b expected 1 1", busy, ram_wEn);
        end
        wr0 = writesA;
        #1 reset_n = 1'b0;
        #1;
        nChecks++;
        if ({busy, done, ram_wEn} !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL abort_flags: got %b expected 000", {busy, done, ram_wEn});
        end
        nChecks++;
        if (ram_addr !== 12'h000 || ram_addr2 !== 12'h000 || ram_dataIn !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL abort_ports: got %h/%h/%h expected 000/000/0", ram_addr, ram_addr2, ram_dataIn);
        end
        @(negedge clk);
        nChecks++;
        if (writesA !== wr0) begin
            nFails++;
            $display("[TB] FAIL abort_no_writes: got %0d writes expected %0d", writesA, wr0);
        end
        reset_n = 1'b1;
        idleThenStart("after_abort");
    endtask

    task automatic test_small_deck(input logic [15:0] sv);
        int deck [0:63];
        int cnt;
        goldenDeck((sv == 16'h0000) ? LFSR_RESET : sv, SN, deck);
        sStart = 1'b1; sSeedLoad = 1'b1; sSeed = sv;
        @(posedge clk);
        @(negedge clk);
        sStart = 1'b0; sSeedLoad = 1'b0;
        cnt = 0;
        while (sBusy === 1'b1 && cnt < 100) begin
            if (cnt == 0) begin
                nChecks++;
                if ({sWEn, sAddr, sDataIn} !== {1'b1, SBASE, 32'd0}) begin
                    nFails++;
                    $display("[TB] FAIL small_init0: got wEn=%b addr=%h data=%0d expected 1 %h 0",
                             sWEn, sAddr, sDataIn, SBASE);
                end
            end
            if (cnt == 1) begin
                nChecks++;
                if ({sWEn, sAddr, sDataIn} !== {1'b1, SBASE + 12'd1, 32'd1}) begin
                    nFails++;
                    $display("[TB] FAIL small_init1: got wEn=%b addr=%h data=%0d expected 1 %h 1",
                             sWEn, sAddr, sDataIn, SBASE + 12'd1);
                end
            end
            cnt++;
            @(negedge clk);
        end
        nChecks++;
        if (cnt !== 5 || sDone !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL small_timing: got busy=%0d done=%b expected busy=5 done=1", cnt, sDone);
        end
        @(negedge clk);
        nChecks++;
        if (memB[SBASE] !== 32'(deck[0]) || memB[SBASE + 12'd1] !== 32'(deck[1])) begin
            nFails++;
            $display("[TB] FAIL small_deck_order: got {%0d,%0d} expected {%0d,%0d}",
                     memB[SBASE], memB[SBASE + 12'd1], deck[0], deck[1]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_then_start();
        test_seed_1234();
        test_seed_zero();
        test_seed_then_wait();
        test_ignore_during_busy();
        test_random_seeds();
        test_reset_abort();
        test_small_deck(16'h0000);
        test_small_deck(16'h1234);
        for (int r = 0; r < 4; r++) test_small_deck(16'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
